// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-access, zero-delay RAM between two
// valid/ready requesters, with a clear engine that zeroes every address.
module ram_arbiter #(
  parameter int ADDRESS_BITS = 1,
  parameter int DATA_BITS    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_write,
  input  logic [ADDRESS_BITS-1:0] req0_address,
  input  logic [DATA_BITS-1:0]    req0_data,
  output logic                    rsp0_valid,
  output logic [DATA_BITS-1:0]    rsp0_data,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_write,
  input  logic [ADDRESS_BITS-1:0] req1_address,
  input  logic [DATA_BITS-1:0]    req1_data,
  output logic                    rsp1_valid,
  output logic [DATA_BITS-1:0]    rsp1_data,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done,
  output logic                    ram_write,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0]    ram_data_in,
  input  logic [DATA_BITS-1:0]    ram_data_out
);

  localparam logic [ADDRESS_BITS-1:0] ADDR_ONE  = ADDRESS_BITS'(1);
  localparam logic [ADDRESS_BITS-1:0] ADDR_LAST = '1;

  typedef enum logic [0:0] {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] count_q, count_d;
  logic                    prio_q, prio_d;
  logic                    rsp0_valid_q, rsp0_valid_d;
  logic [DATA_BITS-1:0]    rsp0_data_q, rsp0_data_d;
  logic                    rsp1_valid_q, rsp1_valid_d;
  logic [DATA_BITS-1:0]    rsp1_data_q, rsp1_data_d;
  logic                    clear_done_q, clear_done_d;
  logic                    grant0_s, grant1_s;

  // Arbitration, RAM drive and next-state; prio_q = 1 means port 1 wins ties.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    prio_d       = prio_q;
    rsp0_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_valid_d = 1'b0;
    rsp1_data_d  = rsp1_data_q;
    clear_done_d = 1'b0;
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    ram_write    = 1'b0;
    ram_address  = '0;
    ram_data_in  = '0;

    case (state_q)
      SERVE: begin
        grant0_s = req0_valid && (!req1_valid || !prio_q);
        grant1_s = req1_valid && !grant0_s;
        if (grant0_s) begin
          ram_write   = req0_write;
          ram_address = req0_address;
          ram_data_in = req0_data;
          prio_d      = 1'b1;
          if (!req0_write) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = ram_data_out;
          end else begin
            rsp0_valid_d = 1'b0;
          end
        end else if (grant1_s) begin
          ram_write   = req1_write;
          ram_address = req1_address;
          ram_data_in = req1_data;
          prio_d      = 1'b0;
          if (!req1_write) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = ram_data_out;
          end else begin
            rsp1_valid_d = 1'b0;
          end
        end else begin
          prio_d = prio_q;
        end
        if (clear_start) begin
          state_d = CLEAR;
        end else begin
          state_d = SERVE;
        end
      end
      CLEAR: begin
        ram_write   = 1'b1;
        ram_address = count_q;
        ram_data_in = '0;
        count_d     = count_q + ADDR_ONE;
        // The counter wraps to 0 naturally after the last address.
        if (count_q == ADDR_LAST) begin
          state_d      = SERVE;
          clear_done_d = 1'b1;
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = SERVE;
      end
    endcase
  end

  // State, sweep counter, priority and registered responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SERVE;
      count_q      <= '0;
      prio_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      prio_q       <= prio_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, directed clear/reset sequences and
// randomized traffic checked against a transaction-level model.
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
  logic [2:0] a0 = 3'd0, a1 = 3'd0;
  logic [3:0] d0 = 4'd0, d1 = 4'd0;
  logic       clear_start = 1'b0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [3:0] rsp0_data, rsp1_data;
  logic       clear_busy, clear_done, ram_write;
  logic [2:0] ram_address;
  logic [3:0] ram_data_in, ram_data_out;

  int errors = 0;
  int checks = 0;

  ram_arbiter #(.ADDRESS_BITS(3), .DATA_BITS(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_write(w0),
    .req0_address(a0), .req0_data(d0),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_write(w1),
    .req1_address(a1), .req1_data(d1),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  // Zero-delay RAM the arbiter sits in front of.
  logic [3:0] ram_mem [8];
  assign ram_data_out = ram_mem[ram_address];
  always @(posedge clock) if (ram_write === 1'b1) ram_mem[ram_address] <= ram_data_in;

  // Reference model: memory contents, who wins a tie, and how far a sweep has got.
  logic [3:0] m_mem [8];
  bit         m_prio1 = 1'b0;
  int         m_sweep = -1;
  bit         m_rv0 = 1'b0, m_rv1 = 1'b0, m_done = 1'b0;
  logic [3:0] m_rd0 = 4'd0, m_rd1 = 4'd0;
  bit         e_g0, e_g1, e_w;
  logic [2:0] e_a;
  logic [3:0] e_d;
  int         busy_cnt, done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task model_comb();
    e_g0 = 1'b0; e_g1 = 1'b0; e_w = 1'b0; e_a = 3'd0; e_d = 4'd0;
    if (m_sweep >= 0) begin
      e_w = 1'b1; e_a = 3'(m_sweep);
    end else if (v0 && (!v1 || !m_prio1)) begin
      e_g0 = 1'b1; e_w = w0; e_a = a0; e_d = d0;
    end else if (v1) begin
      e_g1 = 1'b1; e_w = w1; e_a = a1; e_d = d1;
    end
  endtask

  task model_edge();
    m_rv0  = e_g0 && !w0;
    m_rv1  = e_g1 && !w1;
    if (m_rv0) m_rd0 = m_mem[a0];
    if (m_rv1) m_rd1 = m_mem[a1];
    m_done = (m_sweep == 7);
    if (e_w) m_mem[e_a] = e_d;
    if (e_g0) m_prio1 = 1'b1;
    if (e_g1) m_prio1 = 1'b0;
    if (m_sweep >= 0) m_sweep = (m_sweep == 7) ? -1 : m_sweep + 1;
    else if (clear_start) m_sweep = 0;
    if (reset) begin
      m_sweep = -1; m_prio1 = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
      m_rd0 = 4'd0; m_rd1 = 4'd0; m_done = 1'b0;
    end
  endtask

  task tick();
    @(negedge clock);
    model_comb();
    if (!reset) begin
      chk("req0_ready", req0_ready, e_g0);
      chk("req1_ready", req1_ready, e_g1);
      chk("ram_write", ram_write, e_w);
      chk("ram_address", ram_address, e_a);
      chk("ram_data_in", ram_data_in, e_d);
      chk("rsp0_valid", rsp0_valid, m_rv0);
      chk("rsp0_data", rsp0_data, m_rd0);
      chk("rsp1_valid", rsp1_valid, m_rv1);
      chk("rsp1_data", rsp1_data, m_rd1);
      chk("clear_busy", clear_busy, m_sweep >= 0);
      chk("clear_done", clear_done, m_done);
      if (clear_busy === 1'b1) busy_cnt++;
      if (clear_done === 1'b1) done_cnt++;
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic v0, w0; logic [2:0] a0; logic [3:0] d0;
    logic v1, w1; logic [2:0] a1; logic [3:0] d1;
    logic r0, r1, rw; logic [2:0] ra; logic [3:0] rd;
    logic rv0; logic [3:0] rq0; logic rv1; logic [3:0] rq1;
  } vec_t;

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram_mem[i] = 4'd0;
      m_mem[i]   = 4'd0;
    end
    // Idle, write/read-back across ports, alternating tie-breaks, mixed traffic.
    tbl[0]  = '{1'b0,1'b0,3'd0,4'h0, 1'b0,1'b0,3'd0,4'h0, 1'b0,1'b0,1'b0,3'd0,4'h0, 1'b0,4'h0,1'b0,4'h0};
    tbl[1]  = '{1'b1,1'b1,3'd2,4'h5, 1'b0,1'b0,3'd0,4'h0, 1'b1,1'b0,1'b1,3'd2,4'h5, 1'b0,4'h0,1'b0,4'h0};
    tbl[2]  = '{1'b0,1'b0,3'd0,4'h0, 1'b1,1'b0,3'd2,4'h0, 1'b0,1'b1,1'b0,3'd2,4'h0, 1'b0,4'h0,1'b0,4'h0};
    tbl[3]  = '{1'b0,1'b0,3'd0,4'h0, 1'b0,1'b0,3'd0,4'h0, 1'b0,1'b0,1'b0,3'd0,4'h0, 1'b0,4'h0,1'b1,4'h5};
    tbl[4]  = '{1'b1,1'b0,3'd2,4'h0, 1'b1,1'b0,3'd0,4'h0, 1'b1,1'b0,1'b0,3'd2,4'h0, 1'b0,4'h0,1'b0,4'h5};
    tbl[5]  = '{1'b1,1'b0,3'd2,4'h0, 1'b1,1'b0,3'd0,4'h0, 1'b0,1'b1,1'b0,3'd0,4'h0, 1'b1,4'h5,1'b0,4'h5};
    tbl[6]  = '{1'b1,1'b0,3'd2,4'h0, 1'b1,1'b0,3'd0,4'h0, 1'b1,1'b0,1'b0,3'd2,4'h0, 1'b0,4'h5,1'b1,4'h0};
    tbl[7]  = '{1'b1,1'b0,3'd2,4'h0, 1'b1,1'b0,3'd0,4'h0, 1'b0,1'b1,1'b0,3'd0,4'h0, 1'b1,4'h5,1'b0,4'h0};
    tbl[8]  = '{1'b0,1'b0,3'd0,4'h0, 1'b0,1'b0,3'd0,4'h0, 1'b0,1'b0,1'b0,3'd0,4'h0, 1'b0,4'h5,1'b1,4'h0};
    tbl[9]  = '{1'b0,1'b0,3'd0,4'h0, 1'b1,1'b1,3'd7,4'hA, 1'b0,1'b1,1'b1,3'd7,4'hA, 1'b0,4'h5,1'b0,4'h0};
    tbl[10] = '{1'b1,1'b0,3'd7,4'h0, 1'b1,1'b1,3'd1,4'h3, 1'b1,1'b0,1'b0,3'd7,4'h0, 1'b0,4'h5,1'b0,4'h0};
    tbl[11] = '{1'b0,1'b0,3'd0,4'h0, 1'b1,1'b1,3'd1,4'h3, 1'b0,1'b1,1'b1,3'd1,4'h3, 1'b1,4'hA,1'b0,4'h0};
    tbl[12] = '{1'b0,1'b0,3'd0,4'h0, 1'b0,1'b0,3'd0,4'h0, 1'b0,1'b0,1'b0,3'd0,4'h0, 1'b0,4'hA,1'b0,4'h0};

    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      v0 = tbl[i].v0; w0 = tbl[i].w0; a0 = tbl[i].a0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; w1 = tbl[i].w1; a1 = tbl[i].a1; d1 = tbl[i].d1;
      @(negedge clock);
      model_comb();
      chk("tbl_ready0", req0_ready, tbl[i].r0);
      chk("tbl_ready1", req1_ready, tbl[i].r1);
      chk("tbl_ram_write", ram_write, tbl[i].rw);
      chk("tbl_ram_address", ram_address, tbl[i].ra);
      chk("tbl_ram_data_in", ram_data_in, tbl[i].rd);
      chk("tbl_rsp0_valid", rsp0_valid, tbl[i].rv0);
      chk("tbl_rsp0_data", rsp0_data, tbl[i].rq0);
      chk("tbl_rsp1_valid", rsp1_valid, tbl[i].rv1);
      chk("tbl_rsp1_data", rsp1_data, tbl[i].rq1);
      chk("tbl_clear_busy", clear_busy, 1'b0);
      @(posedge clock);
      model_edge();
      #1;
    end

    // Full sweep with port 0 requesting throughout; it resumes after the sweep.
    busy_cnt = 0; done_cnt = 0;
    v0 = 1'b1; w0 = 1'b0; a0 = 3'd7; d0 = 4'd0; v1 = 1'b0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("sweep_length", busy_cnt, 8);
    chk("sweep_done_pulses", done_cnt, 1);

    // Port 1 write granted alongside clear_start, then zeroed by the sweep.
    v0 = 1'b0; v1 = 1'b1; w1 = 1'b1; a1 = 3'd4; d1 = 4'h9;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    v1 = 1'b1; w1 = 1'b0;
    tick();
    v1 = 1'b0;
    tick();
    tick();

    // Reset at sweep cycle 3 aborts the sweep; the next sweep starts at 0.
    busy_cnt = 0; done_cnt = 0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("aborted_sweep_done", done_cnt, 0);
    chk("aborted_sweep_busy", busy_cnt, 3);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Random traffic; a stalled requester keeps its request stable.
    for (int n = 0; n < 400; n++) begin
      if (!v0 || e_g0) begin
        v0 = ($urandom_range(0, 2) != 0);
        w0 = 1'($urandom_range(0, 1));
        a0 = 3'($urandom_range(0, 7));
        d0 = 4'($urandom_range(0, 15));
      end
      if (!v1 || e_g1) begin
        v1 = ($urandom_range(0, 2) != 0);
        w1 = 1'($urandom_range(0, 1));
        a1 = 3'($urandom_range(0, 7));
        d1 = 4'($urandom_range(0, 15));
      end
      clear_start = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
